// File: rtl/apb_arb_pkg.sv
// Shared types and register map for the APB request arbiter and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Register map of the bridge's APB slave, shared with the slave and benches.
    localparam logic [9:0] DATA_REG_ADDR   = 10'd5;
    localparam logic [9:0] CONFIG_REG_ADDR = 10'd6;
    localparam logic [9:0] STATUS_REG_ADDR = 10'd7;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie, grants the requester not served last.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req[1:0] pending requests, last index served last,
//        gnt[1:0] one-hot grant (zero when idle), gnt_idx index of the grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        gnt     = 2'b00;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
        if (|req) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin accept, SETUP/ACCESS with pready timeout.
// Latency: accept edge -> req_done 3 cycles later (+1 per wait state); 4-cycle minimum per transfer.
// Backpressure: one transfer in flight; req_ready pulses only from IDLE, slave stalls via pready.
// Ports: pclk/preset_n (sync active-low), per-requester req_* (packed, slice i = requester i),
//        req_done/req_rdata/req_err completion, APB master paddr/psel1/penable/pwrite/pwdata/pstrb,
//        slave response pready/prdata/pslverr. All outputs are registered.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,

    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]              req_write,
    input  logic [63:0]             req_wdata,
    input  logic [7:0]              req_strb,
    output logic [1:0]              req_done,
    output logic [31:0]             req_rdata,
    output logic                    req_err,

    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel1,
    output logic                    penable,
    output logic                    pwrite,
    output logic [31:0]             pwdata,
    output logic [3:0]              pstrb,
    input  logic                    pready,
    input  logic [31:0]             prdata,
    input  logic                    pslverr
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_t    state;
    logic          last_gnt;
    logic          cur_idx;
    logic [CW-1:0] wait_cnt;

    logic [1:0]    gnt;
    logic          gnt_idx;

    // Only consulted in IDLE, so the requester in flight is never re-granted.
    rr_arbiter2 u_rr (
        .req     (req_valid),
        .last    (last_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [31:0]           sel_wdata;
    logic [3:0]            sel_strb;

    always_comb begin
        sel_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_write = gnt_idx ? req_write[1] : req_write[0];
        sel_wdata = gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
        sel_strb  = gnt_idx ? req_strb[7:4] : req_strb[3:0];
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;   // requester 0 wins the first tie
            cur_idx   <= 1'b0;
            wait_cnt  <= '0;
            req_ready <= 2'b00;
            req_done  <= 2'b00;
            req_rdata <= '0;
            req_err   <= 1'b0;
            paddr     <= '0;
            psel1     <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            // Handshake and completion strobes are single-cycle pulses.
            req_ready <= 2'b00;
            req_done  <= 2'b00;

            case (state)
                IDLE: begin
                    if (|gnt) begin
                        req_ready <= gnt;
                        cur_idx   <= gnt_idx;
                        paddr     <= sel_addr;
                        pwrite    <= sel_write;
                        // Reads present zero data and strobes on the bus.
                        pwdata    <= sel_write ? sel_wdata : 32'd0;
                        pstrb     <= sel_write ? sel_strb : 4'd0;
                        psel1     <= 1'b1;
                        penable   <= 1'b0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    // pready on the last allowed cycle beats the timeout.
                    if (pready) begin
                        psel1             <= 1'b0;
                        penable           <= 1'b0;
                        req_done[cur_idx] <= 1'b1;
                        req_rdata         <= (!pwrite && !pslverr) ? prdata : 32'd0;
                        req_err           <= pslverr;
                        state             <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        psel1             <= 1'b0;
                        penable           <= 1'b0;
                        req_done[cur_idx] <= 1'b1;
                        req_rdata         <= 32'd0;
                        req_err           <= 1'b1;
                        state             <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    req_rdata <= 32'd0;
                    req_err   <= 1'b0;
                    last_gnt  <= cur_idx;
                    wait_cnt  <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small configurable APB slave.
// Cycle numbers: the accept cycle is the IDLE cycle whose closing edge latches
// the request; req_ready is therefore observed in the cycle after it.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    logic        pclk;
    logic        preset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [19:0] req_addr;
    logic [1:0]  req_write;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        req_err;
    logic [9:0]  paddr;
    logic        psel1;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Slave model knobs.
    int          wait_states = 0;
    bit          never       = 1'b0;
    bit          slv_err     = 1'b0;
    logic [31:0] slv_rdata   = 32'd0;
    int          acc_cnt     = 0;

    apb_req_arbiter dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .paddr     (paddr),
        .psel1     (psel1),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // acc_cnt = number of ACCESS cycles already spent without pready.
    always @(posedge pclk) acc_cnt <= (psel1 && penable && !pready) ? acc_cnt + 1 : 0;
    assign pready  = psel1 && penable && !never && (acc_cnt >= wait_states);
    assign pslverr = pready && slv_err;
    assign prdata  = slv_rdata;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic start_req(input int r, input logic [9:0] a, input logic w,
                             input logic [31:0] wd, input logic [3:0] st);
        req_addr[r*10 +: 10]  = a;
        req_write[r]          = w;
        req_wdata[r*32 +: 32] = wd;
        req_strb[r*4 +: 4]    = st;
        req_valid[r]          = 1'b1;
    endtask

    task automatic wait_ready(input int r, output int c);
        c = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_ready[r]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int r, output int c, output logic [31:0] rd,
                             output logic e, output int acc, output bit strb_nz);
        c = -1; acc = 0; strb_nz = 1'b0; rd = 32'd0; e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) req_valid[r] = 1'b0;
            if (psel1 && penable) acc++;
            if (pstrb != 4'd0) strb_nz = 1'b1;
            if (req_done[r]) begin
                c  = cyc;
                rd = req_rdata;
                e  = req_err;
                break;
            end
        end
        if (c < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        repeat (3) tick();
        preset_n = 1'b1;
    endtask

    int          c_r, c_d, acc, n;
    logic [31:0] rd;
    logic        e;
    bit          snz, done_seen;
    int          order [4];
    int          at [4];
    bit          drop [2];

    initial begin
        preset_n  = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ctl",   32'({req_ready, req_done, req_err, psel1, penable, pwrite}), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_data",  req_rdata | pwdata, 32'd0);
        check("rst_pstrb", 32'(pstrb), 32'd0);
        preset_n = 1'b1;
        tick();

        // Single write, zero wait states
        wait_states = 0; never = 1'b0; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
        start_req(0, DATA_REG_ADDR, 1'b1, 32'hA5A5_1234, 4'hF);
        wait_ready(0, c_r);
        check("t1_setup_psel", 32'(psel1), 32'd1);
        check("t1_setup_pen",  32'(penable), 32'd0);
        check("t1_paddr",      32'(paddr), 32'd5);
        check("t1_pwrite",     32'(pwrite), 32'd1);
        check("t1_pwdata",     pwdata, 32'hA5A5_1234);
        check("t1_pstrb",      32'(pstrb), 32'hF);
        wait_done(0, c_d, rd, e, acc, snz);
        check("t1_access_cycles", 32'(acc), 32'd1);
        check("t1_latency",       32'(c_d - (c_r - 1)), 32'd3);
        check("t1_err",           32'(e), 32'd0);
        check("t1_rdata",         rd, 32'd0);
        tick();
        check("t1_paddr_hold", 32'(paddr), 32'd5);
        check("t1_psel_idle",  32'(psel1), 32'd0);

        // Read with three wait states
        wait_states = 3; slv_rdata = 32'h0000_003C;
        start_req(1, CONFIG_REG_ADDR, 1'b0, 32'hFFFF_FFFF, 4'hF);
        wait_ready(1, c_r);
        check("t2_pstrb_setup",  32'(pstrb), 32'd0);
        check("t2_pwdata_setup", pwdata, 32'd0);
        check("t2_paddr",        32'(paddr), 32'd6);
        wait_done(1, c_d, rd, e, acc, snz);
        check("t2_access_cycles", 32'(acc), 32'd4);
        check("t2_latency",       32'(c_d - (c_r - 1)), 32'd6);
        check("t2_rdata",         rd, 32'h3C);
        check("t2_err",           32'(e), 32'd0);
        check("t2_pstrb_nonzero", 32'(snz), 32'd0);
        tick();
        check("t2_rdata_cleared", req_rdata, 32'd0);

        // Slave error on read
        wait_states = 0; slv_err = 1'b1; slv_rdata = 32'hFFFF_FFFF;
        start_req(0, 10'h009, 1'b0, 32'd0, 4'd0);
        wait_ready(0, c_r);
        wait_done(0, c_d, rd, e, acc, snz);
        check("t5_err",   32'(e), 32'd1);
        check("t5_rdata", rd, 32'd0);
        tick();
        check("t5_err_cleared", 32'(req_err), 32'd0);
        slv_err = 1'b0;

        // Timeout: no pready at all
        never = 1'b1; slv_rdata = 32'hCAFE_0001;
        start_req(0, CONFIG_REG_ADDR, 1'b0, 32'd0, 4'd0);
        wait_ready(0, c_r);
        wait_done(0, c_d, rd, e, acc, snz);
        check("t4_access_cycles", 32'(acc), 32'd16);
        check("t4_latency",       32'(c_d - (c_r - 1)), 32'd18);
        check("t4_err",           32'(e), 32'd1);
        check("t4_rdata",         rd, 32'd0);
        check("t4_psel_at_done",  32'(psel1), 32'd0);
        tick();

        // pready on the 16th ACCESS cycle wins over the timeout
        never = 1'b0; wait_states = 15; slv_rdata = 32'h1234_5678;
        start_req(0, CONFIG_REG_ADDR, 1'b0, 32'd0, 4'd0);
        wait_ready(0, c_r);
        wait_done(0, c_d, rd, e, acc, snz);
        check("t4b_access_cycles", 32'(acc), 32'd16);
        check("t4b_err",           32'(e), 32'd0);
        check("t4b_rdata",         rd, 32'h1234_5678);
        tick();

        // Contention from reset: grants alternate 0,1,0,1 every 4 cycles
        wait_states = 0;
        start_req(0, DATA_REG_ADDR, 1'b1, 32'h1111_0000, 4'hF);
        start_req(1, STATUS_REG_ADDR, 1'b1, 32'h2222_0000, 4'h1);
        do_reset();
        n = 0; drop[0] = 1'b0; drop[1] = 1'b0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            for (int r = 0; r < 2; r++) begin
                if (drop[r]) begin
                    req_valid[r] = 1'b0;
                    drop[r] = 1'b0;
                end
                if (req_ready[r] && n < 4) begin
                    order[n] = r;
                    at[n]    = cyc;
                    n++;
                    drop[r]  = 1'b1;
                end
                if (req_done[r]) req_valid[r] = 1'b1;
            end
        end
        req_valid = 2'b00;
        check("t3_grant_count", 32'(n), 32'd4);
        if (n == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("t3_order%0d", k), 32'(order[k]), 32'(k % 2));
            for (int k = 1; k < 4; k++) check($sformatf("t3_spacing%0d", k), 32'(at[k] - at[k-1]), 32'd4);
        end
        repeat (4) tick();

        // Reset in the middle of an ACCESS phase
        never = 1'b1;
        start_req(1, STATUS_REG_ADDR, 1'b1, 32'h0BAD_F00D, 4'h3);
        wait_ready(1, c_r);
        tick();
        check("t6_in_access", 32'(penable), 32'd1);
        req_valid[1] = 1'b0;
        slv_rdata = 32'h0000_00A7;
        start_req(0, DATA_REG_ADDR, 1'b0, 32'd0, 4'd0);
        preset_n = 1'b0;
        tick();
        check("t6_rst_ctl",   32'({req_ready, req_done, req_err, psel1, penable, pwrite}), 32'd0);
        check("t6_rst_paddr", 32'(paddr), 32'd0);
        check("t6_rst_data",  req_rdata | pwdata, 32'd0);
        check("t6_rst_pstrb", 32'(pstrb), 32'd0);
        done_seen = (req_done != 2'b00);
        repeat (2) begin
            tick();
            if (req_done != 2'b00) done_seen = 1'b1;
        end
        preset_n = 1'b1;
        never = 1'b0;
        tick();
        if (req_done != 2'b00) done_seen = 1'b1;
        check("t6_no_done",          32'(done_seen), 32'd0);
        check("t6_accept_first_cyc", 32'(req_ready), 32'd1);
        wait_done(0, c_d, rd, e, acc, snz);
        check("t6_rdata_after", rd, 32'h0000_00A7);
        check("t6_err_after",   32'(e), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
